uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Next-generation UART peripheral for the on-chip bus: one self-contained block containing the bus register file, TX/RX engines, and TX/RX FIFOs.
- Adds a runtime-programmable baud divisor, optional even/odd parity, parametrised FIFO depth, and sticky error flags.
- The previous single-byte-buffer UART has none of these.
- Sits on the same bus slot as the existing UART and drives the same two interrupt lines.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, minimum 2.
- DIV_W, 16, width of the baud divisor register.
- DEFAULT_DIV, 260, divisor loaded at reset, in clocks per bit.
- ADDR_W, 2, bus address width; word registers 0..3.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- cs_  in  1  chip select, active low.
- as_  in  1  address strobe, active low.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  register select.
- wr_data  in  32  write data.
- rd_data  out  32  read data.
- rdy_  out  1  access acknowledge, active low.
- irq_rx  out  1  RX interrupt, level.
- irq_tx  out  1  TX interrupt, level.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output, idle high.

Behaviour:
- Access strobe: an access occurs in any cycle with cs_=0 and as_=0.
- Access timing: rdy_ goes 0 and rd_data becomes valid on the following cycle, for exactly one cycle.
- Non-read cycles: rd_data=0 whenever the block is not returning read data.
- Reset values: rd_data=0, rdy_=1, irq_rx=0, irq_tx=0, tx=1; both FIFOs empty; CTRL=0; DIV=DEFAULT_DIV; all error flags 0.
- Reset mid-operation: reset is asynchronous. A frame in flight is abandoned, tx goes high immediately, and FIFO contents are lost.
- Register map, addr 0, CTRL (RW): [0] rx_ie, [1] tx_ie, [2] par_en, [3] par_odd.
- Register map, addr 1, STATUS:
  - Read-only bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full.
  - Sticky bits, write-1-to-clear: [4] overrun, [5] parity_err, [6] frame_err.
  - Count fields: [15:8] rx_count, [23:16] tx_count.
- Register map, addr 2, DATA:
  - Write pushes wr_data[7:0] to the TX FIFO. If the FIFO is full the byte is dropped and there is no flag.
  - Read pops the RX FIFO and returns the byte in [7:0]. If the FIFO is empty the read returns 0 and pointers do not move.
- Register map, addr 3, DIV (RW): [DIV_W-1:0]. Written values below 4 are stored as 4.
- DIV changes: take effect at the next frame start; the current frame keeps its latched divisor.
- Frame format: start(0), 8 data bits LSB first, optional parity bit, 1 stop bit(1).
  - Each bit lasts DIV clocks.
  - Even parity: parity bit = XOR of data. Odd parity: its inverse.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START when the TX FIFO is non-empty; pops the byte in the same cycle.
  - PARITY is skipped when par_en=0.
  - STOP returns to IDLE. Back-to-back frames carry no extra idle bit.
- RX input synchronisation: rx passes through a 2-flop synchroniser.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on a synchronised falling edge.
  - START samples at DIV/2 clocks (integer floor). If the sample reads 1 the start is a glitch and the FSM returns to IDLE.
  - Later bits are sampled every DIV clocks after the start-bit midpoint.
- RX frame completion, at the stop-bit sample:
  - stop=0: set frame_err and discard the byte.
  - Parity mismatch (par_en=1): set parity_err and discard the byte.
  - Otherwise push the byte to the RX FIFO. If the FIFO is full, set overrun and discard.
- FIFO arithmetic: pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Simultaneous push and pop: count is unchanged and both operations succeed, including when the FIFO is full. The pop frees the slot.
- Status write vs error set in the same cycle: the set wins over a W1C clear.
- irq_rx (registered): rx_ie & (!rx_empty | overrun | parity_err | frame_err).
- irq_tx (registered): tx_ie & tx_empty & TX FSM in IDLE.
- Latency: bytes written to an idle TX FIFO drive the start bit on tx within 2 cycles of the write access.

Test Plan:
- Reset values: reset low, then release -> tx=1, rdy_=1, rd_data=0. A read of addr1 returns 0x00000005 (rx_empty, tx_empty). A read of addr3 returns 260.
- TX parity frames: DIV=8, CTRL=0x4, write 0xA5 -> tx shows 0, 1,0,1,0,0,1,0,1, parity 0, 1, each bit 8 clocks. Setting par_odd gives parity bit 1.
- RX loopback: tx looped to rx, DIV=16, write 0x3C, 0xFF, 0x00 -> rx_count reaches 3 and DATA reads return 0x3C, 0xFF, 0x00. Then STATUS rx_empty=1.
- FIFO full and overrun: inject FIFO_DEPTH+1 frames with no reads -> rx_full=1, overrun=1, first 16 bytes intact. Write 0x10 to STATUS clears overrun.
- Frame and glitch errors: a frame with stop=0 -> frame_err=1, rx_count unchanged. A 2-clock low glitch on rx with DIV=16 -> no RX activity.
- Interrupts and abort: with rx_ie=1, a received byte raises irq_rx, and reading DATA drops it next cycle. Asserting reset mid-TX frame drives tx=1 immediately.

Source files
------------

// File: rtl/uart_fifo.sv
// UART peripheral: bus register file, programmable-baud TX/RX engines with parity, TX/RX FIFOs.
// Reads and acknowledges land one cycle after the access; a DATA write to a full TX FIFO is dropped.
module uart_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 260,
  parameter int ADDR_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  output logic              irq_rx,
  output logic              irq_tx,
  input  logic              rx,
  output logic              tx
);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(3);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [3:0]       r_ctrl;
  logic [DIV_W-1:0] r_div;
  logic             r_overrun, r_parity_err, r_frame_err;
  logic [31:0]      r_rd_data;
  logic             r_rdy_n, r_irq_rx, r_irq_tx;

  logic w_access, w_wr, w_rd;
  logic w_wr_ctrl, w_wr_stat, w_wr_data, w_wr_div, w_rd_data;
  logic [DIV_W-1:0] w_div_wr;
  logic [31:0] w_rd_mux;
  logic w_unused;

  logic          w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
  logic [7:0]    w_tx_head;
  logic [PW-1:0] w_tx_count;
  logic          w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
  logic [7:0]    w_rx_head;
  logic [PW-1:0] w_rx_count, w_rx_count_nxt;

  state_t           r_tx_state, w_tx_state_nxt;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
  logic [7:0]       r_tx_shift;
  logic [2:0]       r_tx_idx;
  logic             r_tx_par, r_tx_par_en, r_tx;
  logic             w_tx_bit_done;

  state_t           r_rx_state, w_rx_state_nxt;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div;
  logic [7:0]       r_rx_shift;
  logic [2:0]       r_rx_idx;
  logic             r_rx_par_en, r_rx_par_odd, r_rx_par_bit;
  logic             w_rx_fall, w_rx_tick, w_rx_done, w_rx_ok, w_rx_par_bad;
  logic             w_overrun_set, w_parity_set, w_frame_set;
  logic             w_overrun_nxt, w_parity_nxt, w_frame_nxt;

  assign w_access  = ~cs_ & ~as_;
  assign w_wr      = w_access & ~rw;
  assign w_rd      = w_access & rw;
  assign w_wr_ctrl = w_wr & (addr == A_CTRL);
  assign w_wr_stat = w_wr & (addr == A_STAT);
  assign w_wr_data = w_wr & (addr == A_DATA);
  assign w_wr_div  = w_wr & (addr == A_DIV);
  assign w_rd_data = w_rd & (addr == A_DATA);
  assign w_div_wr  = (wr_data[DIV_W-1:0] < DIV_W'(4)) ? DIV_W'(4) : wr_data[DIV_W-1:0];
  assign w_unused  = ^wr_data;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign w_tx_push = w_wr_data & (~w_tx_full | w_tx_pop);
  assign w_rx_pop  = w_rd_data & ~w_rx_empty;
  assign w_rx_push = w_rx_ok & (~w_rx_full | w_rx_pop);

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .i_clk(clk), .i_rst_n(reset), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_dat(wr_data[7:0]), .o_dat(w_tx_head), .o_count(w_tx_count),
    .o_empty(w_tx_empty), .o_full(w_tx_full)
  );

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .i_clk(clk), .i_rst_n(reset), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_dat(r_rx_shift), .o_dat(w_rx_head), .o_count(w_rx_count),
    .o_empty(w_rx_empty), .o_full(w_rx_full)
  );

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      A_CTRL: w_rd_mux = {28'b0, r_ctrl};
      A_STAT: w_rd_mux = {8'b0, 8'(w_tx_count), 8'(w_rx_count), 1'b0, r_frame_err,
                          r_parity_err, r_overrun, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
      A_DATA: w_rd_mux = w_rx_empty ? 32'b0 : {24'b0, w_rx_head};
      A_DIV:  w_rd_mux = 32'(r_div);
      default: w_rd_mux = '0;
    endcase
  end

  assign w_overrun_set = w_rx_ok & w_rx_full & ~w_rx_pop;
  assign w_overrun_nxt = w_overrun_set | (r_overrun & ~(w_wr_stat & wr_data[4]));
  assign w_parity_nxt  = w_parity_set | (r_parity_err & ~(w_wr_stat & wr_data[5]));
  assign w_frame_nxt   = w_frame_set | (r_frame_err & ~(w_wr_stat & wr_data[6]));
  assign w_rx_count_nxt = w_rx_count + PW'(w_rx_push) - PW'(w_rx_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl       <= '0;
      r_div        <= DIV_W'(DEFAULT_DIV);
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rd_data    <= '0;
      r_rdy_n      <= 1'b1;
      r_irq_rx     <= 1'b0;
      r_irq_tx     <= 1'b0;
    end else begin
      r_rdy_n      <= ~w_access;
      r_rd_data    <= w_rd ? w_rd_mux : 32'b0;
      if (w_wr_ctrl) r_ctrl <= wr_data[3:0];
      if (w_wr_div)  r_div  <= w_div_wr;
      r_overrun    <= w_overrun_nxt;
      r_parity_err <= w_parity_nxt;
      r_frame_err  <= w_frame_nxt;
      // Built from next-cycle FIFO/flag state so a DATA read drops the line with the ack.
      r_irq_rx     <= r_ctrl[0] & ((w_rx_count_nxt != '0) | w_overrun_nxt | w_parity_nxt | w_frame_nxt);
      r_irq_tx     <= r_ctrl[1] & w_tx_empty & (r_tx_state == S_IDLE);
    end
  end

  assign rd_data = r_rd_data;
  assign rdy_    = r_rdy_n;
  assign irq_rx  = r_irq_rx;
  assign irq_tx  = r_irq_tx;
  assign tx      = r_tx;

  assign w_tx_bit_done = (r_tx_cnt == r_tx_div - DIV_W'(1));

  // A non-empty FIFO at the end of STOP chains straight into the next start bit.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      S_IDLE: if (!w_tx_empty) begin
        w_tx_state_nxt = S_START;
        w_tx_pop       = 1'b1;
      end
      S_START: if (w_tx_bit_done) w_tx_state_nxt = S_DATA;
      S_DATA: if (w_tx_bit_done && r_tx_idx == 3'd7)
        w_tx_state_nxt = r_tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_bit_done) w_tx_state_nxt = S_STOP;
      S_STOP: if (w_tx_bit_done) begin
        if (!w_tx_empty) begin
          w_tx_state_nxt = S_START;
          w_tx_pop       = 1'b1;
        end else begin
          w_tx_state_nxt = S_IDLE;
        end
      end
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state  <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_div    <= DIV_W'(DEFAULT_DIV);
      r_tx_shift  <= '0;
      r_tx_idx    <= '0;
      r_tx_par    <= 1'b0;
      r_tx_par_en <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_pop) begin
        r_tx_shift  <= w_tx_head;
        r_tx_par    <= (^w_tx_head) ^ r_ctrl[3];
        r_tx_par_en <= r_ctrl[2];
        r_tx_div    <= r_div;
        r_tx_cnt    <= '0;
        r_tx_idx    <= '0;
        r_tx        <= 1'b0;
      end else if (r_tx_state != S_IDLE) begin
        if (w_tx_bit_done) begin
          r_tx_cnt <= '0;
          case (r_tx_state)
            S_START: r_tx <= r_tx_shift[0];
            S_DATA: begin
              if (r_tx_idx == 3'd7) begin
                r_tx <= r_tx_par_en ? r_tx_par : 1'b1;
              end else begin
                r_tx_idx   <= r_tx_idx + 3'd1;
                r_tx_shift <= r_tx_shift >> 1;
                r_tx       <= r_tx_shift[1];
              end
            end
            default: r_tx <= 1'b1;
          endcase
        end else begin
          r_tx_cnt <= r_tx_cnt + DIV_W'(1);
        end
      end
    end
  end

  // The edge is seen one flop after the synchroniser, so the start sample waits DIV/2-1 counts.
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_tick = (r_rx_state == S_START) ? (r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1))
                                             : (r_rx_cnt == r_rx_div - DIV_W'(1));

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      S_IDLE:   if (w_rx_fall) w_rx_state_nxt = S_START;
      S_START:  if (w_rx_tick) w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_tick && r_rx_idx == 3'd7)
        w_rx_state_nxt = r_rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_tick) w_rx_state_nxt = S_STOP;
      S_STOP: if (w_rx_tick) begin
        w_rx_state_nxt = S_IDLE;
        w_rx_done      = 1'b1;
      end
      default: w_rx_state_nxt = S_IDLE;
    endcase
  end

  assign w_rx_par_bad = r_rx_par_en & (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));
  assign w_frame_set  = w_rx_done & ~r_rx_s2;
  assign w_parity_set = w_rx_done & r_rx_s2 & w_rx_par_bad;
  assign w_rx_ok      = w_rx_done & r_rx_s2 & ~w_rx_par_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_div     <= DIV_W'(DEFAULT_DIV);
      r_rx_shift   <= '0;
      r_rx_idx     <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_bit <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      if (r_rx_state == S_IDLE) begin
        r_rx_cnt     <= '0;
        r_rx_idx     <= '0;
        r_rx_div     <= r_div;
        r_rx_par_en  <= r_ctrl[2];
        r_rx_par_odd <= r_ctrl[3];
      end else if (w_rx_tick) begin
        r_rx_cnt <= '0;
        if (r_rx_state == S_DATA) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 3'd1;
        end
        if (r_rx_state == S_PARITY) r_rx_par_bit <= r_rx_s2;
      end else begin
        r_rx_cnt <= r_rx_cnt + DIV_W'(1);
      end
    end
  end
endmodule

// Synchronous FIFO with wrapping pointer-difference count; head is presented combinationally.
// Zero-latency head; callers gate push/pop with full/empty (push on full is legal alongside a pop).
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_dat,
  output logic [W-1:0]           o_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rptr[AW-1:0]];
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: bus register access, TX framing, RX loopback, FIFO/overrun, errors, irqs, abort.
`timescale 1ns/1ps
module tb_uart_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        rdy_, irq_rx, irq_tx, tx;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        rx_line;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic       exp_bits[$];

  assign rx_line = loopback ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo #(.FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(260), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_rx(irq_rx),
    .irq_tx(irq_tx), .rx(rx_line), .tx(tx)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    @(negedge clk); cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    @(negedge clk); cs_ = 1'b1; as_ = 1'b1; d = rd_data;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (div) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic push_tx_bits(input logic [7:0] d, input logic pe, input logic po);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pe) exp_bits.push_back((^d) ^ po);
    exp_bits.push_back(1'b1);
  endtask

  task automatic monitor_tx(input string name, input int div);
    int lat;
    int idx;
    logic b;
    lat = 0;
    while (tx !== 1'b0 && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (tx !== 1'b0 || lat > 2) begin
      fails++;
      $display("FAIL %s_latency: start bit after %0d cycles (tx=%b), required <= 2", name, lat, tx);
      exp_bits.delete();
      return;
    end
    repeat (div / 2) @(negedge clk);
    idx = 0;
    while (exp_bits.size() > 0) begin
      b = exp_bits.pop_front();
      tests++;
      if (tx !== b) begin
        fails++;
        $display("FAIL %s_bit%0d: tx=%b required %b", name, idx, tx, b);
      end
      idx++;
      repeat (div) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || rdy_ !== 1'b1 || rd_data !== 32'd0 || irq_rx !== 1'b0 || irq_tx !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: tx=%b rdy_=%b rd_data=%h irq_rx=%b irq_tx=%b, required 1 1 0 0 0",
               tx, rdy_, rd_data, irq_rx, irq_tx);
    end
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h5 || rdy_ !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: rd_data=%h rdy_=%b, required 00000005 0", d, rdy_);
    end
    @(negedge clk);
    tests++;
    if (rdy_ !== 1'b1 || rd_data !== 32'd0) begin
      fails++;
      $display("FAIL ack_one_cycle: rdy_=%b rd_data=%h, required 1 0", rdy_, rd_data);
    end
    bus_read(2'd3, d);
    tests++;
    if (d !== 32'd260) begin fails++; $display("FAIL reset_div: got %0d required 260", d); end
    bus_read(2'd0, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_ctrl: got %h required 0", d); end
  endtask

  task automatic test_div_clamp();
    logic [31:0] d;
    int wv[3] = '{1, 3, 5};
    int ev[3] = '{4, 4, 5};
    for (int i = 0; i < 3; i++) begin
      bus_write(2'd3, 32'(wv[i]));
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'(ev[i])) begin
        fails++;
        $display("FAIL div_clamp_%0d: got %0d required %0d", wv[i], d, ev[i]);
      end
    end
  endtask

  task automatic test_tx_parity();
    bus_write(2'd3, 32'd8);
    bus_write(2'd0, 32'h4);
    push_tx_bits(8'hA5, 1'b1, 1'b0);
    bus_write(2'd2, 32'hA5);
    monitor_tx("tx_even", 8);
    bus_write(2'd0, 32'hC);
    push_tx_bits(8'hA5, 1'b1, 1'b1);
    bus_write(2'd2, 32'hA5);
    monitor_tx("tx_odd", 8);
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_back_to_back_loopback();
    logic [31:0] d;
    logic [7:0] e;
    int polls;
    loopback = 1'b1;
    bus_write(2'd3, 32'd16);
    exp_q.push_back(8'h3C); bus_write(2'd2, 32'h3C);
    exp_q.push_back(8'hFF); bus_write(2'd2, 32'hFF);
    exp_q.push_back(8'h00); bus_write(2'd2, 32'h00);
    polls = 0;
    d = 32'd0;
    while (d[15:8] != 8'd3 && polls < 100) begin
      repeat (10) @(negedge clk);
      bus_read(2'd1, d);
      polls++;
    end
    tests++;
    if (d[15:8] !== 8'd3) begin fails++; $display("FAIL loop_count: rx_count=%0d required 3", d[15:8]); end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd2, d);
      e = exp_q.pop_front();
      tests++;
      if (d !== {24'd0, e}) begin fails++; $display("FAIL loop_data%0d: got %h required %h", i, d, e); end
    end
    bus_read(2'd1, d);
    tests++;
    if (d[0] !== 1'b1) begin fails++; $display("FAIL loop_empty: rx_empty=%b required 1", d[0]); end
    loopback = 1'b0;
  endtask

  task automatic test_fifo_overrun();
    logic [31:0] d;
    logic [7:0] b, e;
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 13 + 7);
      if (i < 16) exp_q.push_back(b);
      send_rx(b, 1'b1, 16);
    end
    bus_read(2'd1, d);
    tests++;
    if (d[1] !== 1'b1 || d[15:8] !== 8'd16) begin
      fails++; $display("FAIL rx_full: rx_full=%b rx_count=%0d required 1 16", d[1], d[15:8]);
    end
    tests++;
    if (d[4] !== 1'b1) begin fails++; $display("FAIL overrun_set: overrun=%b required 1", d[4]); end
    bus_write(2'd1, 32'h10);
    bus_read(2'd1, d);
    tests++;
    if (d[4] !== 1'b0 || d[1] !== 1'b1) begin
      fails++; $display("FAIL overrun_clear: overrun=%b rx_full=%b required 0 1", d[4], d[1]);
    end
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd2, d);
      e = exp_q.pop_front();
      tests++;
      if (d !== {24'd0, e}) begin fails++; $display("FAIL full_data%0d: got %h required %h", i, d, e); end
    end
  endtask

  task automatic test_frame_glitch();
    logic [31:0] d;
    send_rx(8'h81, 1'b0, 16);
    bus_read(2'd1, d);
    tests++;
    if (d[6] !== 1'b1 || d[15:8] !== 8'd0) begin
      fails++; $display("FAIL frame_err: frame_err=%b rx_count=%0d required 1 0", d[6], d[15:8]);
    end
    bus_write(2'd1, 32'h40);
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL frame_clear: status=%h required 00000005", d); end
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL glitch: status=%h required 00000005", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [7:0] e;
    int waits;
    bus_write(2'd0, 32'h1);
    @(negedge clk);
    tests++;
    if (irq_rx !== 1'b0) begin fails++; $display("FAIL irq_rx_idle: irq_rx=%b required 0", irq_rx); end
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1, 16);
    waits = 0;
    while (irq_rx !== 1'b1 && waits < 50) begin @(negedge clk); waits++; end
    tests++;
    if (irq_rx !== 1'b1) begin fails++; $display("FAIL irq_rx_raise: irq_rx=%b required 1", irq_rx); end
    bus_read(2'd2, d);
    e = exp_q.pop_front();
    tests++;
    if (d !== {24'd0, e} || irq_rx !== 1'b0) begin
      fails++; $display("FAIL irq_rx_drop: data=%h irq_rx=%b required %h 0", d, irq_rx, e);
    end
    bus_write(2'd0, 32'h2);
    repeat (2) @(negedge clk);
    tests++;
    if (irq_tx !== 1'b1 || irq_rx !== 1'b0) begin
      fails++; $display("FAIL irq_tx: irq_tx=%b irq_rx=%b required 1 0", irq_tx, irq_rx);
    end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int waits;
    bus_write(2'd2, 32'h00);
    waits = 0;
    while (tx !== 1'b0 && waits < 10) begin @(negedge clk); waits++; end
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL abort_start: tx=%b required 0", tx); end
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || rdy_ !== 1'b1) begin
      fails++; $display("FAIL abort_tx: tx=%b rdy_=%b required 1 1", tx, rdy_);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL abort_status: status=%h required 00000005", d); end
    bus_read(2'd3, d);
    tests++;
    if (d !== 32'd260) begin fails++; $display("FAIL abort_div: div=%0d required 260", d); end
  endtask

  initial begin
    test_reset();
    test_div_clamp();
    test_tx_parity();
    test_back_to_back_loopback();
    test_fifo_overrun();
    test_frame_glitch();
    test_irq();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
